// File: rtl/crash_manager.sv
// Crash manager: accumulates player/obstacle pixel collisions over a video
// frame, and at each frame end runs the RUN / CRASH / OVER game flow.
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   pixel_x, pixel_y  current VGA column / row
//   video_on          high inside the active display area
//   on_player         player car pixel hit
//   on_obs[5:0]       per-obstacle visible pixel hit
//   start             restart request (honoured only in OVER)
//   crash, freeze, blink, game_over, lives, hit_mask   registered status outputs
module crash_manager #(
    parameter int unsigned CRASH_FRAMES = 60,
    parameter int unsigned BLINK_HALF   = 4,
    parameter int unsigned START_LIVES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       on_player,
    input  logic [5:0] on_obs,
    input  logic       start,
    output logic       crash,
    output logic       freeze,
    output logic       blink,
    output logic       game_over,
    output logic [1:0] lives,
    output logic [5:0] hit_mask
);

    localparam int unsigned OBS_W  = 6;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LIVE_W = 2;
    localparam int unsigned Y_W    = 10;

    localparam logic [Y_W-1:0]    FRAME_END_Y = Y_W'(480);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(CRASH_FRAMES - 1);
    localparam logic [CNT_W-1:0]  BLINK_DIV   = CNT_W'(BLINK_HALF);
    localparam logic [LIVE_W-1:0] LIVES_INIT  = LIVE_W'(START_LIVES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CRASH = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [OBS_W-1:0]    acc, acc_nxt;
    logic [OBS_W-1:0]    hit_mask_nxt;
    logic [CNT_W-1:0]    frame_cnt, frame_cnt_nxt;
    logic [CNT_W-1:0]    blink_quot;
    logic [LIVE_W-1:0]   lives_nxt;
    logic                y_at_end_q;
    logic                frame_end;
    logic [OBS_W-1:0]    hit;
    logic                crash_nxt, freeze_nxt, blink_nxt, game_over_nxt;

    // Column position carries no information for collision bookkeeping.
    logic unused_pixel_x;
    assign unused_pixel_x = ^pixel_x;

    // Frame end fires once, on the first cycle the row reaches 480.
    assign frame_end = (pixel_y == FRAME_END_Y) && !y_at_end_q;
    assign hit       = (video_on && on_player) ? on_obs : '0;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_RUN;
            acc        <= '0;
            frame_cnt  <= '0;
            lives      <= LIVES_INIT;
            hit_mask   <= '0;
            y_at_end_q <= 1'b0;
            crash      <= 1'b0;
            freeze     <= 1'b0;
            blink      <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            frame_cnt  <= frame_cnt_nxt;
            lives      <= lives_nxt;
            hit_mask   <= hit_mask_nxt;
            y_at_end_q <= (pixel_y == FRAME_END_Y);
            crash      <= crash_nxt;
            freeze     <= freeze_nxt;
            blink      <= blink_nxt;
            game_over  <= game_over_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt     = state;
        lives_nxt     = lives;
        hit_mask_nxt  = hit_mask;
        frame_cnt_nxt = frame_cnt;
        // Hits landing on the frame-end cycle belong to no frame and are dropped.
        acc_nxt       = frame_end ? '0 : (acc | hit);

        case (state)
            ST_RUN: begin
                if (frame_end && (acc != '0)) begin
                    hit_mask_nxt  = acc;
                    frame_cnt_nxt = '0;
                    lives_nxt     = (lives != '0) ? (lives - LIVE_W'(1)) : '0;
                    state_nxt     = (lives <= LIVE_W'(1)) ? ST_OVER : ST_CRASH;
                end
            end
            ST_CRASH: begin
                if (frame_end) begin
                    if (frame_cnt == CNT_LAST) begin
                        frame_cnt_nxt = '0;
                        state_nxt     = ST_RUN;
                    end else begin
                        frame_cnt_nxt = frame_cnt + CNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                // Restart wins over a coincident frame end.
                if (start) begin
                    lives_nxt     = LIVES_INIT;
                    hit_mask_nxt  = '0;
                    frame_cnt_nxt = '0;
                    acc_nxt       = '0;
                    state_nxt     = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output decode from the state about to be registered.
    always_comb begin
        crash_nxt     = 1'b0;
        freeze_nxt    = 1'b0;
        game_over_nxt = 1'b0;
        blink_nxt     = 1'b0;
        blink_quot    = frame_cnt_nxt / BLINK_DIV;
        case (state_nxt)
            ST_CRASH: begin
                crash_nxt  = 1'b1;
                freeze_nxt = 1'b1;
                blink_nxt  = blink_quot[0];
            end
            ST_OVER: begin
                freeze_nxt    = 1'b1;
                game_over_nxt = 1'b1;
            end
            default: begin
                crash_nxt = 1'b0;
            end
        endcase
    end

endmodule
